lockin_modulator: RTL and testbench
===================================

// Module: lockin_modulator
// PURPOSE
//  Excitation generator: produces the modulated drive and clean cosine reference consumed by the lock-in demodulator.
//  - NCO phase accumulator, shared quarter-wave sine LUT, one time-multiplexed multiplier.
//  - signal_o = amp_x*cos(phase) + amp_y*sin(phase).
//  - One output sample per tick_i; sits between the control/DAC side and the ADC sample clock domain logic.
// PARAMETERS
//  NUM_BITS       24  sample/amplitude width, signed Q1.(NUM_BITS-1)
//  PHASE_BITS     32  phase accumulator width (2^PHASE_BITS = one full turn)
//  LUT_ADDR_BITS  10  quarter-wave LUT address width (2^LUT_ADDR_BITS+1 entries)
// PORTS
//  clk_i          in   1            system clock
//  reset_ni       in   1            asynchronous, active-low reset
//  tick_i         in   1            sample strobe, one-cycle pulse
//  freq_word_i    in   PHASE_BITS   phase increment per tick (unsigned)
//  phase_ofs_i    in   PHASE_BITS   phase offset added before lookup
//  amp_x_i        in   NUM_BITS     signed in-phase amplitude
//  amp_y_i        in   NUM_BITS     signed quadrature amplitude
//  signal_o       out  NUM_BITS     modulated output sample
//  ref_o          out  NUM_BITS     cos(phase) reference, full scale
//  done_o         out  1            one-cycle pulse: signal_o/ref_o updated
//  overrun_o      out  1            sticky: tick_i arrived while busy
// BEHAVIOUR
//  - Reset (async, reset_ni=0): signal_o=0, ref_o=0, done_o=0, overrun_o=0, phase_acc=0, state=IDLE.
//  - FSM: IDLE -> LUT_COS -> LUT_SIN -> MUL_X -> MUL_Y -> SUM -> IDLE.
//  - IDLE + tick_i: latch amp_x_i, amp_y_i; lookup phase p = phase_acc + phase_ofs_i (mod 2^PHASE_BITS);
//    phase_acc <= phase_acc + freq_word_i (wraps silently).
//  - LUT address = p[PHASE_BITS-3 -: LUT_ADDR_BITS]; quadrant = p[PHASE_BITS-1:PHASE_BITS-2]; LUT output registered, 1 cycle.
//  - Cos lookup uses p + 2^(PHASE_BITS-2).
//  - Quadrant map for sin, i = index:
//    - q0: +T[i]
//    - q1: +T[2^A-i]
//    - q2: -T[i]
//    - q3: -T[2^A-i]
//  - T[k] = round(FULL_SCALE*sin(k*pi/2^(A+1))), with FULL_SCALE = 2^(NUM_BITS-1)-1.
//  - Products are 2*NUM_BITS wide; term = prod[2*NUM_BITS-2 -: NUM_BITS] (Q1.23 x Q1.23 -> Q1.23, truncate).
//  - SUM: sum formed at NUM_BITS+1 bits, then narrowed per CONFIGURATION; ref_o <= cos value.
//  - Latency: tick_i sampled in cycle 0 -> done_o=1 in cycle 6, with signal_o and ref_o valid in that same cycle. Outputs hold until next done_o.
//  - tick_i in any state other than IDLE: tick ignored, phase_acc not advanced, overrun_o <= 1. overrun_o stays set until reset.
//  - Input changes after the IDLE tick have no effect on the sample in flight.
//  - Reset mid-operation: immediate return to reset values; a partial sample is never emitted.
// CONFIGURATION
//  LOCKIN_MOD_SATURATE_EN
//   - defined: the NUM_BITS+1-bit sum clamps to [-2^(NUM_BITS-1), 2^(NUM_BITS-1)-1].
//   - undefined: the sum is truncated to its low NUM_BITS bits (two's-complement wrap).
// STRUCTURE
//  - Package lockin_pkg: state enum lockin_mod_state_e; NUM_BITS default; FULL_SCALE constant; quadrant typedef.
//  - Sub-module lockin_sine_lut:
//    - ROM of 2^LUT_ADDR_BITS+1 entries, generated at elaboration.
//    - Quadrant mapping plus registered output.
//  - Top level holds the FSM, phase accumulator, multiplier and summer.
// TESTING
//  1. freq_word=0, ofs=0, amp_x=8388607, amp_y=0, one tick -> done_o in cycle 6; ref_o=8388607; signal_o=8388606.
//  2. freq_word=2^30, amp_x=8388607, amp_y=0, 4 ticks every 10 cycles -> ref_o=8388607, 0, -8388607, 0.
//  3. ofs=2^29 (45 deg), amp_x=amp_y=8388607 -> SATURATE_EN: signal_o=8388607; without it: the wrapped value (negative).
//  4. Second tick 2 cycles after the first -> exactly one done_o; overrun_o=1 and sticky; phase_acc advanced once.
//  5. reset_ni low in MUL_X -> all outputs 0 immediately; no done_o; the next tick restarts from phase 0.
//  6. freq_word=2^31+1 for 2^10 ticks -> phase wraps with no glitch; ref_o matches the golden model bit-exactly.

Source files
------------

// File: rtl/lockin_modulator_pkg.sv
// Shared types, default sizes and the elaboration-time sine table generator
// for the lock-in excitation generator.
package lockin_pkg;

  localparam int NUM_BITS_DEFAULT      = 24;
  localparam int PHASE_BITS_DEFAULT    = 32;
  localparam int LUT_ADDR_BITS_DEFAULT = 10;
  localparam real PI = 3.14159265358979323846;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LUT_COS = 3'd1,
    ST_LUT_SIN = 3'd2,
    ST_MUL_X   = 3'd3,
    ST_MUL_Y   = 3'd4,
    ST_SUM     = 3'd5
  } lockin_mod_state_e;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quadrant_e;

  function automatic longint full_scale(input int nb);
    return (longint'(1) << (nb - 1)) - longint'(1);
  endfunction

  localparam longint FULL_SCALE = full_scale(NUM_BITS_DEFAULT);

  // Quarter-wave entry k of 2^addr_bits+1: round(FS*sin(k*pi/2^(addr_bits+1))).
  function automatic longint sine_entry(input int k, input int addr_bits, input int nb);
    real ang;
    real val;
    ang = PI * real'(k) / real'(longint'(1) << (addr_bits + 1));
    val = real'(full_scale(nb)) * $sin(ang);
    return longint'($rtoi(val + 0.5));
  endfunction

endpackage

// File: rtl/lockin_modulator_if.sv
// Sample strobe, configuration and result bundle of lockin_modulator.
interface lockin_modulator_if
  import lockin_pkg::*;
#(
  parameter int NUM_BITS   = NUM_BITS_DEFAULT,
  parameter int PHASE_BITS = PHASE_BITS_DEFAULT
);
  logic                         tick_i;
  logic        [PHASE_BITS-1:0] freq_word_i;
  logic        [PHASE_BITS-1:0] phase_ofs_i;
  logic signed [NUM_BITS-1:0]   amp_x_i;
  logic signed [NUM_BITS-1:0]   amp_y_i;
  logic signed [NUM_BITS-1:0]   signal_o;
  logic signed [NUM_BITS-1:0]   ref_o;
  logic                         done_o;
  logic                         overrun_o;

  modport master (
    output tick_i, freq_word_i, phase_ofs_i, amp_x_i, amp_y_i,
    input  signal_o, ref_o, done_o, overrun_o
  );

  modport slave (
    input  tick_i, freq_word_i, phase_ofs_i, amp_x_i, amp_y_i,
    output signal_o, ref_o, done_o, overrun_o
  );
endinterface

// File: rtl/lockin_modulator_sine_lut.sv
// Quarter-wave sine ROM with quadrant folding and a registered output;
// i_phase carries the top LUT_ADDR_BITS+2 bits of the lookup phase.
module lockin_sine_lut
  import lockin_pkg::*;
#(
  parameter int NUM_BITS      = NUM_BITS_DEFAULT,
  parameter int LUT_ADDR_BITS = LUT_ADDR_BITS_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic [LUT_ADDR_BITS+1:0]   i_phase,
  output logic signed [NUM_BITS-1:0] o_value
);

  localparam int DEPTH = (1 << LUT_ADDR_BITS) + 1;

  logic signed [NUM_BITS-1:0] w_rom [DEPTH];
  quadrant_e                  w_quad;
  logic [LUT_ADDR_BITS-1:0]   w_idx;
  logic [LUT_ADDR_BITS:0]     w_addr;
  logic signed [NUM_BITS-1:0] w_mag;
  logic                       w_negate;
  logic signed [NUM_BITS-1:0] r_value;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic signed [NUM_BITS-1:0] ENTRY = NUM_BITS'(sine_entry(k, LUT_ADDR_BITS, NUM_BITS));
    assign w_rom[k] = ENTRY;
  end

  assign w_quad   = quadrant_e'(i_phase[LUT_ADDR_BITS+1 -: 2]);
  assign w_idx    = i_phase[LUT_ADDR_BITS-1:0];
  assign w_negate = (w_quad == QUAD_2) || (w_quad == QUAD_3);

  // Odd quadrants read the table mirrored; the extra entry 2^A holds full scale.
  always_comb begin
    w_addr = {1'b0, w_idx};
    if ((w_quad == QUAD_1) || (w_quad == QUAD_3))
      w_addr = {1'b1, {LUT_ADDR_BITS{1'b0}}} - {1'b0, w_idx};
    w_mag = w_rom[w_addr];
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)
      r_value <= '0;
    else if (w_negate)
      r_value <= -w_mag;
    else
      r_value <= w_mag;
  end

  assign o_value = r_value;

endmodule

// File: rtl/lockin_modulator.sv
// NCO excitation generator: signal = amp_x*cos + amp_y*sin, ref = cos, one sample per tick.
// Build option LOCKIN_MOD_SATURATE_EN clamps the final sum instead of wrapping it.
module lockin_modulator
  import lockin_pkg::*;
#(
  parameter int NUM_BITS      = NUM_BITS_DEFAULT,
  parameter int PHASE_BITS    = PHASE_BITS_DEFAULT,
  parameter int LUT_ADDR_BITS = LUT_ADDR_BITS_DEFAULT
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  lockin_modulator_if.slave bus
);

  localparam int NB  = NUM_BITS;
  localparam int TOP = LUT_ADDR_BITS + 2;
  localparam int LOW = PHASE_BITS - TOP;

  // states: IDLE wait tick | LUT_COS cos addr | LUT_SIN sin addr, cos out
  //         | MUL_X amp_x*cos | MUL_Y amp_y*sin | SUM emit sample
  lockin_mod_state_e r_state, w_state_next;

  logic [PHASE_BITS-1:0] r_phase_acc;
  logic [TOP-1:0]        r_lookup;
  logic [TOP-1:0]        w_lookup_next;
  logic [TOP-1:0]        w_lut_phase;
  logic                  w_ofs_carry;

  logic signed [NB-1:0]   r_amp_x, r_amp_y;
  logic signed [NB-1:0]   r_cos;
  logic signed [NB-1:0]   r_term_x, r_term_y;
  logic signed [NB-1:0]   r_signal, r_ref;
  logic                   r_done, r_overrun;
  logic signed [NB-1:0]   w_lut;
  logic signed [NB-1:0]   w_mul_a, w_mul_b;
  logic signed [2*NB-1:0] w_prod;
  logic signed [NB-1:0]   w_term;
  logic signed [NB:0]     w_sum;
  logic signed [NB-1:0]   w_sum_narrow;

  logic w_accept, w_busy_tick, w_cos_sel, w_cap_cos, w_load_x, w_load_y, w_emit;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:    if (bus.tick_i) w_state_next = ST_LUT_COS;
      ST_LUT_COS: w_state_next = ST_LUT_SIN;
      ST_LUT_SIN: w_state_next = ST_MUL_X;
      ST_MUL_X:   w_state_next = ST_MUL_Y;
      ST_MUL_Y:   w_state_next = ST_SUM;
      ST_SUM:     w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_accept  = 1'b0;
    w_cos_sel = 1'b0;
    w_cap_cos = 1'b0;
    w_load_x  = 1'b0;
    w_load_y  = 1'b0;
    w_emit    = 1'b0;
    unique case (r_state)
      ST_IDLE:    w_accept  = bus.tick_i;
      ST_LUT_COS: w_cos_sel = 1'b1;
      ST_LUT_SIN: w_cap_cos = 1'b1;
      ST_MUL_X:   w_load_x  = 1'b1;
      ST_MUL_Y:   w_load_y  = 1'b1;
      ST_SUM:     w_emit    = 1'b1;
      default:    ;
    endcase
    w_busy_tick = bus.tick_i && (r_state != ST_IDLE);
  end

  // Only the top TOP bits of acc+ofs reach the LUT; the low half contributes its carry.
  assign w_ofs_carry   = bus.phase_ofs_i[LOW-1:0] > ~r_phase_acc[LOW-1:0];
  assign w_lookup_next = r_phase_acc[PHASE_BITS-1 -: TOP] + bus.phase_ofs_i[PHASE_BITS-1 -: TOP]
                       + {{(TOP-1){1'b0}}, w_ofs_carry};
  assign w_lut_phase   = w_cos_sel ? {r_lookup[TOP-1 -: 2] + 2'b01, r_lookup[TOP-3:0]} : r_lookup;

  lockin_sine_lut #(
    .NUM_BITS      (NUM_BITS),
    .LUT_ADDR_BITS (LUT_ADDR_BITS)
  ) u_lut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .i_phase  (w_lut_phase),
    .o_value  (w_lut)
  );

  // During MUL_Y the LUT still presents the sine addressed in LUT_SIN/MUL_X.
  assign w_mul_a = w_load_y ? r_amp_y : r_amp_x;
  assign w_mul_b = w_load_y ? w_lut : r_cos;
  assign w_prod  = $signed({{NB{w_mul_a[NB-1]}}, w_mul_a}) * $signed({{NB{w_mul_b[NB-1]}}, w_mul_b});
  assign w_term  = w_prod[2*NB-2 -: NB];
  assign w_sum   = {r_term_x[NB-1], r_term_x} + {r_term_y[NB-1], r_term_y};

`ifdef LOCKIN_MOD_SATURATE_EN
  always_comb begin
    w_sum_narrow = w_sum[NB-1:0];
    if (w_sum[NB] != w_sum[NB-1])
      w_sum_narrow = w_sum[NB] ? {1'b1, {(NB-1){1'b0}}} : {1'b0, {(NB-1){1'b1}}};
  end
`else
  assign w_sum_narrow = w_sum[NB-1:0];
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_phase_acc <= '0;
      r_lookup    <= '0;
      r_amp_x     <= '0;
      r_amp_y     <= '0;
      r_cos       <= '0;
      r_term_x    <= '0;
      r_term_y    <= '0;
      r_signal    <= '0;
      r_ref       <= '0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_amp_x     <= bus.amp_x_i;
        r_amp_y     <= bus.amp_y_i;
        r_lookup    <= w_lookup_next;
        r_phase_acc <= r_phase_acc + bus.freq_word_i;
      end
      if (w_cap_cos) r_cos <= w_lut;
      if (w_load_x) r_term_x <= w_term;
      if (w_load_y) r_term_y <= w_term;
      if (w_emit) begin
        r_signal <= w_sum_narrow;
        r_ref    <= r_cos;
      end
      r_done <= w_emit;
      if (w_busy_tick) r_overrun <= 1'b1;
    end
  end

  assign bus.signal_o  = r_signal;
  assign bus.ref_o     = r_ref;
  assign bus.done_o    = r_done;
  assign bus.overrun_o = r_overrun;

endmodule

// File: tb/tb_lockin_modulator.sv
// Scoreboard bench for lockin_modulator: ticks push expected samples, a monitor
// pops and compares on every done_o.
`timescale 1ns/1ps
module tb_lockin_modulator;

  localparam longint FS   = 64'sd8388607;
  localparam real    PI_R = 3.14159265358979323846;

  typedef struct {
    logic signed [23:0] sig;
    logic signed [23:0] rf;
    longint             cyc;
    string              name;
  } exp_t;

  logic   clk_i    = 1'b0;
  logic   reset_ni = 1'b0;
  longint cyc      = 0;
  exp_t   sb[$];
  int     n_total  = 0;
  int     n_pass   = 0;
  bit [31:0] m_acc = '0;

  lockin_modulator_if #(.NUM_BITS(24), .PHASE_BITS(32)) bus();

  lockin_modulator dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, req);
  endtask

  // Full-turn 4096-step angle from the top 12 phase bits, symmetric rounding.
  function automatic logic signed [23:0] model_wave(input bit [31:0] p, input bit cosine);
    real    a, v;
    longint r;
    a = 2.0 * PI_R * real'(int'(p[31:20])) / 4096.0;
    v = real'(FS) * (cosine ? $cos(a) : $sin(a));
    if (v >= 0.0) r = longint'($rtoi(v + 0.5));
    else          r = -longint'($rtoi(-v + 0.5));
    return r[23:0];
  endfunction

  function automatic logic signed [23:0] model_term(input logic signed [23:0] a,
                                                    input logic signed [23:0] c);
    longint pr;
    pr = longint'(a) * longint'(c);
    return pr[46:23];
  endfunction

  function automatic logic signed [23:0] model_sum(input logic signed [23:0] a,
                                                   input logic signed [23:0] b);
    longint s;
    s = longint'(a) + longint'(b);
`ifdef LOCKIN_MOD_SATURATE_EN
    if (s > FS) return 24'sh7FFFFF;
    if (s < -FS - 1) return 24'sh800000;
`endif
    return s[23:0];
  endfunction

  task automatic do_tick(input bit [31:0] fw, input bit [31:0] ofs,
                         input logic signed [23:0] ax, input logic signed [23:0] ay,
                         input bit accept, input string nm);
    exp_t      e;
    bit [31:0] p;
    @(negedge clk_i);
    bus.freq_word_i = fw;
    bus.phase_ofs_i = ofs;
    bus.amp_x_i     = ax;
    bus.amp_y_i     = ay;
    bus.tick_i      = 1'b1;
    if (accept) begin
      p      = m_acc + ofs;
      e.rf   = model_wave(p, 1'b1);
      e.sig  = model_sum(model_term(ax, model_wave(p, 1'b1)), model_term(ay, model_wave(p, 1'b0)));
      e.cyc  = cyc + 6;
      e.name = nm;
      sb.push_back(e);
      m_acc  = m_acc + fw;
    end
    @(negedge clk_i);
    bus.tick_i      = 1'b0;
    bus.amp_x_i     = ~ax;
    bus.amp_y_i     = ~ay;
    bus.phase_ofs_i = ofs ^ 32'h5A5A_5A5A;
    bus.freq_word_i = ~fw;
  endtask

  task automatic drain(input string nm);
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    if (sb.size() != 0) begin
      check({nm, "_timeout"}, longint'(sb.size()), 0);
      sb.delete();
    end
    repeat (2) @(negedge clk_i);
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (reset_ni && bus.done_o) begin
      if (sb.size() == 0) begin
        check("unexpected_done", longint'(bus.done_o), 0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_ref"},     longint'(bus.ref_o),    longint'(e.rf));
        check({e.name, "_signal"},  longint'(bus.signal_o), longint'(e.sig));
        check({e.name, "_latency"}, cyc,                    e.cyc);
      end
    end
  end

  logic signed [23:0] ax_tab [4];
  logic signed [23:0] ay_tab [4];

  initial begin
    ax_tab = '{24'sh7FFFFF, -24'sd4194304, 24'sd1234567, 24'sh800000};
    ay_tab = '{24'sd0, 24'sh7FFFFF, -24'sd3000001, 24'sd2500000};
    bus.tick_i      = 1'b0;
    bus.freq_word_i = '0;
    bus.phase_ofs_i = '0;
    bus.amp_x_i     = '0;
    bus.amp_y_i     = '0;
    reset_ni        = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset_signal",  longint'(bus.signal_o),  0);
    check("reset_ref",     longint'(bus.ref_o),     0);
    check("reset_done",    longint'(bus.done_o),    0);
    check("reset_overrun", longint'(bus.overrun_o), 0);
    reset_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // single tick at phase 0, full-scale in-phase amplitude
    do_tick(32'd0, 32'd0, 24'sh7FFFFF, 24'sd0, 1'b1, "t1");
    drain("t1");
    check("t1_ref_hold",    longint'(bus.ref_o),    8388607);
    check("t1_signal_hold", longint'(bus.signal_o), 8388606);

    // quarter-turn steps
    for (int i = 0; i < 4; i++) begin
      do_tick(32'h4000_0000, 32'd0, 24'sh7FFFFF, 24'sd0, 1'b1, "t2");
      repeat (8) @(negedge clk_i);
    end
    drain("t2");
    check("t2_last_ref", longint'(bus.ref_o), 0);

    // 45 degree offset, both amplitudes full scale: sum overflows
    do_tick(32'd0, 32'h2000_0000, 24'sh7FFFFF, 24'sh7FFFFF, 1'b1, "t3");
    drain("t3");
`ifdef LOCKIN_MOD_SATURATE_EN
    check("t3_saturated", longint'(bus.signal_o), 8388607);
`else
    check("t3_wrapped", longint'(bus.signal_o), -4913936);
`endif

    // second tick while busy is dropped and flagged
    do_tick(32'h4000_0000, 32'd0, 24'sh7FFFFF, 24'sd0, 1'b1, "t4a");
    do_tick(32'h8000_0000, 32'd0, 24'sh800000, 24'sh800000, 1'b0, "t4b");
    drain("t4a");
    check("t4_overrun", longint'(bus.overrun_o), 1);
    do_tick(32'h4000_0000, 32'd0, 24'sd0, 24'sh7FFFFF, 1'b1, "t4c");
    drain("t4c");
    check("t4_ref_after_one_advance", longint'(bus.ref_o),    0);
    check("t4_signal",                longint'(bus.signal_o), 8388606);
    check("t4_overrun_sticky",        longint'(bus.overrun_o), 1);

    // reset while in MUL_X
    do_tick(32'h4000_0000, 32'd0, 24'sh7FFFFF, 24'sh7FFFFF, 1'b0, "t5abort");
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b0;
    #1;
    check("t5_signal_cleared",  longint'(bus.signal_o),  0);
    check("t5_ref_cleared",     longint'(bus.ref_o),     0);
    check("t5_done_cleared",    longint'(bus.done_o),    0);
    check("t5_overrun_cleared", longint'(bus.overrun_o), 0);
    m_acc = '0;
    repeat (3) @(negedge clk_i);
    reset_ni = 1'b1;
    repeat (10) @(negedge clk_i);
    do_tick(32'h4000_0000, 32'd0, 24'sh7FFFFF, 24'sd0, 1'b1, "t5restart");
    drain("t5restart");
    check("t5_restart_ref", longint'(bus.ref_o), 8388607);

    // long run with a wrapping frequency word
    for (int i = 0; i < 1024; i++) begin
      do_tick(32'h8000_0001, 32'd0, ax_tab[i % 4], ay_tab[i % 4], 1'b1, "t6");
      repeat (5) @(negedge clk_i);
    end
    drain("t6");
    check("t6_no_overrun", longint'(bus.overrun_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
